// File: rtl/serial_adder.sv
// Digit-serial adder/subtractor: WIDTH-bit operands, DIGIT bits per cycle, valid/ready on both sides.
// Optional signed-overflow output via `define SERIAL_ADDER_OVF_EN.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned D  = DIGIT;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_next;
  logic [DIGIT-1:0] a_slice, b_slice, s_slice;
  logic             c_slice;
  logic             last;
  int unsigned      base;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = RUN;
      RUN:     if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // One slice per cycle; the partial result is built in acc and only published to sum on the last slice.
  always_comb begin
    base     = 32'(cnt) * D;
    a_slice  = a_reg[base +: DIGIT];
    b_slice  = b_reg[base +: DIGIT];
    {c_slice, s_slice} = {1'b0, a_slice} + {1'b0, b_slice} + (DIGIT+1)'(carry);
    acc_next = acc;
    acc_next[base +: DIGIT] = s_slice;
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_next;
          carry <= c_slice;
          cnt   <= cnt + CW'(1);
          if (last) begin
            sum  <= acc_next;
            cout <= c_slice;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic msb_carry_in;
  logic ovf_reg;

  // Carry into the MSB recovered from the MSB's own sum bit and operand bits.
  assign msb_carry_in = s_slice[DIGIT-1] ^ a_slice[DIGIT-1] ^ b_slice[DIGIT-1];

  always_ff @(posedge clk) begin
    if (reset) ovf_reg <= 1'b0;
    else if (state == RUN && last) ovf_reg <= msb_carry_in ^ c_slice;
  end

  assign ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: arithmetic/timing model for a 16/4 instance plus directed
// literal checks, and a directed 8/8 instance.
module tb_serial_adder;

  localparam int W = 16;
  localparam int D = 4;
  localparam int N = W / D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          in_valid, in_ready, sub, cin, out_valid, out_ready, cout;
  logic [W-1:0]  a, b, sum;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf;
`endif

  logic          iv2, ir2, sub2, cin2, ov2, or2, cout2;
  logic [7:0]    a2, b2, sum2;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf2;
`endif

  serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(8)) dut2 (
    .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2),
    .a(a2), .b(b2), .sub(sub2), .cin(cin2),
    .out_valid(ov2), .out_ready(or2), .sum(sum2), .cout(cout2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: result is plain arithmetic on the captured operands; it appears N edges after accept.
  bit          chk_en = 1'b0;
  bit          m_busy, m_done;
  int          m_left;
  logic [15:0] m_sum, p_sum, bb;
  logic        m_cout, p_cout, m_ovf, p_ovf;
  logic [16:0] full;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      chk_en = 1'b1;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0; m_done = 1'b1;
        m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (in_valid) begin
      bb     = sub ? ~b : b;
      full   = {1'b0, a} + {1'b0, bb} + 17'(sub ? 1'b1 : cin);
      p_sum  = full[15:0];
      p_cout = full[16];
      p_ovf  = (a[15] == bb[15]) && (full[15] != a[15]);
      m_left = N;
      m_busy = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_in_ready", 32'(in_ready), 32'(!(m_busy || m_done)));
      check("model_out_valid", 32'(out_valid), 32'(m_done));
      check("model_sum", 32'(sum), 32'(m_sum));
      check("model_cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
      check("model_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge where out_valid is seen.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic ts, input logic tc,
                        output int lat);
    in_valid = 1'b1; a = ta; b = tb_v; sub = ts; cin = tc; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ta, tb_v;
    logic        ts, tc;
    logic [15:0] es;
    logic        ec;
  } vec_t;

  vec_t vecs[5] = '{
    '{16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5556, 1'b0},
    '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1},
    '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0},
    '{16'hABCD, 16'hABCD, 1'b1, 1'b0, 16'h0000, 1'b1},
    '{16'h0F0F, 16'h00F1, 1'b0, 1'b1, 16'h1001, 1'b0}
  };

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    int seen;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b0;
    iv2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; cin2 = 1'b0; or2 = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst2_in_ready", 32'(ir2), 32'd1);
    check("rst2_sum", 32'(sum2), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat);
    check("wrap_latency", 32'(lat), 32'd4);
    check("wrap_sum", 32'(sum), 32'h0000);
    check("wrap_cout", 32'(cout), 32'd1);
    release_op();
    check("wrap_back_idle", 32'(in_ready), 32'd1);

    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat);
    check("sub_sum", 32'(sum), 32'hFFFE);
    check("sub_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("sub_ovf", 32'(ovf), 32'd0);
`endif
    release_op();

    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat);
    check("ovf_sum", 32'(sum), 32'h8000);
    check("ovf_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
    check("ovf_flag", 32'(ovf), 32'd1);
`endif
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 16'(i * 16'h1111 + 16'h0F0F);
      @(posedge clk);
      @(negedge clk);
      check("bp_sum", 32'(sum), 32'h8000);
      check("bp_cout", 32'(cout), 32'd0);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].ta, vecs[i].tb_v, vecs[i].ts, vecs[i].tc, lat);
      check("vec_latency", 32'(lat), 32'(N));
      check("vec_sum", 32'(sum), 32'(vecs[i].es));
      check("vec_cout", 32'(cout), 32'(vecs[i].ec));
      release_op();
    end

    in_valid = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0; cin = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check("midrun_rst_sum", 32'(sum), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("midrun_no_result", 32'(seen), 32'd0);

    iv2 = 1'b1; a2 = 8'h80; b2 = 8'h80; sub2 = 1'b0; cin2 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv2 = 1'b0;
    check("w8_busy_after_accept", 32'(ov2), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("w8_out_valid", 32'(ov2), 32'd1);
    check("w8_sum", 32'(sum2), 32'h01);
    check("w8_cout", 32'(cout2), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
    check("w8_ovf", 32'(ovf2), 32'd1);
`endif
    or2 = 1'b1;
    @(negedge clk);
    or2 = 1'b0;
    check("w8_back_idle", 32'(ir2), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter DIGIT, default 4, bits added per cycle; WIDTH SHALL be an integer multiple of DIGIT (N = WIDTH/DIGIT).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  operands a, b, sub, cin are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  first operand.
REQ-008 SHALL have port b  input  WIDTH  second operand.
REQ-009 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-010 SHALL have port cin  input  1  carry-in, used in add mode only.
REQ-011 SHALL have port out_valid  output  1  sum, cout (and ovf) are valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result.
REQ-014 SHALL have port cout  output  1  carry-out of MSB.

Function
REQ-015 SHALL implement states IDLE, RUN, DONE; in_ready = (state == IDLE); out_valid = (state == DONE).
REQ-016 SHALL, in IDLE when in_valid & in_ready, capture a, b, sub, cin, clear the digit counter and enter RUN at the same edge.
REQ-017 SHALL, in add mode, compute a + b + cin; in subtract mode, compute a + ~b + 1 with cin ignored.
REQ-018 SHALL process one DIGIT-bit slice per RUN cycle, least significant slice first, carrying the registered carry into the next slice.
REQ-019 SHALL enter DONE at the edge that processes slice N-1; out_valid SHALL rise exactly N edges after the accepting edge (N = 1 when DIGIT = WIDTH).
REQ-020 SHALL hold sum, cout (and ovf) stable in DONE until out_valid & out_ready, then return to IDLE at that edge.
REQ-021 SHALL ignore in_valid and all operand inputs while in RUN or DONE.
REQ-022 SHALL keep sum, cout (and ovf) at their last completed values while in IDLE and RUN, changing only on the edge that enters DONE.
REQ-023 cout SHALL equal the carry out of bit WIDTH-1 (in subtract mode, cout = 1 means no borrow).

Reset
REQ-024 SHALL, when reset is high at a rising edge, enter IDLE and clear the counter, carry, sum, cout and ovf to 0, regardless of state.
REQ-025 SHALL discard any in-progress operation on reset mid-RUN or mid-DONE; no out_valid SHALL follow for that operation.
REQ-026 After reset: in_ready = 1, out_valid = 0, sum = 0, cout = 0.

Configuration
REQ-027 SHALL, when macro SERIAL_ADDER_OVF_EN is defined, provide port ovf  output  1, set in DONE to the two's-complement signed overflow of the operation (carry into MSB XOR carry out of MSB).
REQ-028 SHALL, when SERIAL_ADDER_OVF_EN is undefined, omit port ovf and all related logic; all other behaviour identical.

Verification
REQ-029 WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, sub=0, cin=0 -> sum=0x0000, cout=1, out_valid rises 4 edges after accept.
REQ-030 a=0x0005, b=0x0007, sub=1, cin=1 -> sum=0xFFFE, cout=0 (cin ignored), ovf=0 when enabled.
REQ-031 SERIAL_ADDER_OVF_EN defined: a=0x7FFF, b=0x0001, sub=0, cin=0 -> sum=0x8000, cout=0, ovf=1.
REQ-032 Backpressure: out_ready held low 3 cycles in DONE with in_valid=1 and changing a -> sum/cout stable, in_ready=0, no new capture; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-033 Reset asserted on 2nd RUN cycle of a=0x1234, b=0x1111 -> next cycle IDLE, in_ready=1, out_valid=0, sum=0; no result for that operation ever appears.
REQ-034 WIDTH=8, DIGIT=8: a=0x80, b=0x80, sub=0, cin=1 -> sum=0x01, cout=1, out_valid 1 edge after accept.
